// File: rtl/handshake_const_arbiter.sv
// Arbitrates NUM_REQ control-token requesters onto one constant-emitting output slot.
// Define HANDSHAKE_CONST_ARB_RR_EN for round-robin; otherwise the lowest valid index always wins.
module handshake_const_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 32,
    parameter     CONST_VALUE = 32'h0001_FB3C,
    parameter int IDX_W       = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    ins_valid,
    output logic [NUM_REQ-1:0]    ins_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic [IDX_W-1:0]      outs_index,
    output logic                  outs_valid,
    input  logic                  outs_ready
);

    localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    logic                   r_full;
    logic [IDX_W-1:0]       r_idx;
    logic [IDX_W-1:0]       w_start;
    logic [2*NUM_REQ-1:0]   w_dbl;
    logic [NUM_REQ-1:0]     w_rot;
    logic [IDX_W-1:0]       w_off;
    logic [IDX_W:0]         w_sum;
    logic [IDX_W-1:0]       w_grant;
    logic                   w_any;
    logic                   w_can_load;
    logic                   w_fire;

`ifdef HANDSHAKE_CONST_ARB_RR_EN
    logic [IDX_W-1:0]       r_ptr;

    assign w_start = r_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (w_fire) begin
            r_ptr <= (w_grant == LAST_IDX) ? '0 : w_grant + IDX_W'(1);
        end
    end
`else
    assign w_start = '0;
`endif

    // Rotate the requests so the search always starts at bit 0, then map the offset back.
    assign w_dbl = {ins_valid, ins_valid};
    assign w_rot = NUM_REQ'(w_dbl >> w_start);

    always_comb begin
        w_any = 1'b0;
        w_off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_any = 1'b1;
                w_off = IDX_W'(k);
            end
        end
    end

    assign w_sum   = {1'b0, w_start} + {1'b0, w_off};
    assign w_grant = (w_sum >= NUM_REQ_W) ? IDX_W'(w_sum - NUM_REQ_W) : w_sum[IDX_W-1:0];

    // Gating with rst keeps every ready low while reset is held.
    assign w_can_load = !r_full || outs_ready;
    assign w_fire     = w_can_load && w_any && rst;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign ins_ready[gi] = w_fire && (w_grant == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_full <= 1'b0;
            r_idx  <= '0;
        end else if (w_fire) begin
            r_full <= 1'b1;
            r_idx  <= w_grant;
        end else if (outs_ready) begin
            r_full <= 1'b0;
        end
    end

    assign outs       = DATA_WIDTH'(CONST_VALUE);
    assign outs_index = r_idx;
    assign outs_valid = r_full;

endmodule

// File: tb/tb_handshake_const_arbiter.sv
// Directed bench for handshake_const_arbiter; expectations follow the build's arbitration mode.
module tb_handshake_const_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  ins_valid = 4'b0000;
    logic [3:0]  ins_ready;
    logic [31:0] outs;
    logic [1:0]  outs_index;
    logic        outs_valid;
    logic        outs_ready = 1'b0;

    int total = 0;
    int bad   = 0;

    handshake_const_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (32),
        .CONST_VALUE(32'h0001_FB3C)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ins_valid (ins_valid),
        .ins_ready (ins_ready),
        .outs      (outs),
        .outs_index(outs_index),
        .outs_valid(outs_valid),
        .outs_ready(outs_ready)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        ins_valid  = 4'b0000;
        outs_ready = 1'b0;
        cycle();
        cycle();
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        ins_valid  = 4'b1111;
        outs_ready = 1'b1;
        cycle();
        cycle();
        total++; if (ins_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b exp=0000", ins_ready); end
        total++; if (outs_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", outs_valid); end
        total++; if (outs_index !== 2'd0) begin bad++; $display("FAIL reset_index got=%0d exp=0", outs_index); end
        total++; if (outs !== 32'h0001FB3C) begin bad++; $display("FAIL reset_outs got=%h exp=0001fb3c", outs); end
        rst = 1'b1;
        #1;
        total++; if (ins_ready !== 4'b0001) begin bad++; $display("FAIL release_ready got=%b exp=0001", ins_ready); end
        cycle();
        total++; if (outs_valid !== 1'b1 || outs_index !== 2'd0) begin bad++; $display("FAIL release_grant got=%b/%0d exp=1/0", outs_valid, outs_index); end
        $display("reset: ready=%b valid=%b index=%0d", ins_ready, outs_valid, outs_index);
    endtask

    task automatic test_rotation();
`ifdef HANDSHAKE_CONST_ARB_RR_EN
        int exp_g[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
`else
        int exp_g[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
`endif
        logic [3:0] e;
        do_reset();
        ins_valid  = 4'b1111;
        outs_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            e = 4'b0001 << exp_g[c];
            total++; if (ins_ready !== e) begin bad++; $display("FAIL rot_ready[%0d] got=%b exp=%b", c, ins_ready, e); end
            cycle();
            total++; if (outs_valid !== 1'b1 || outs_index !== 2'(exp_g[c])) begin bad++; $display("FAIL rot_index[%0d] got=%b/%0d exp=1/%0d", c, outs_valid, outs_index, exp_g[c]); end
            $display("rotation %0d: grant=%0d", c, outs_index);
        end
    endtask

    task automatic test_sparse();
        logic [3:0] vec[7] = '{4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b0001, 4'b1001, 4'b1001};
`ifdef HANDSHAKE_CONST_ARB_RR_EN
        int exp_g[7] = '{1, 3, 1, 3, 0, 3, 0};
`else
        int exp_g[7] = '{1, 1, 1, 1, 0, 0, 0};
`endif
        logic [3:0] e;
        do_reset();
        outs_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            ins_valid = vec[c];
            #1;
            e = 4'b0001 << exp_g[c];
            total++; if (ins_ready !== e) begin bad++; $display("FAIL sparse_ready[%0d] got=%b exp=%b", c, ins_ready, e); end
            cycle();
            total++; if (outs_index !== 2'(exp_g[c])) begin bad++; $display("FAIL sparse_index[%0d] got=%0d exp=%0d", c, outs_index, exp_g[c]); end
            $display("sparse %0d: valid=%b grant=%0d", c, vec[c], outs_index);
        end
    endtask

    task automatic test_backpressure();
`ifdef HANDSHAKE_CONST_ARB_RR_EN
        logic [3:0] e_next = 4'b0010;
        logic [1:0] i_next = 2'd1;
`else
        logic [3:0] e_next = 4'b0001;
        logic [1:0] i_next = 2'd0;
`endif
        do_reset();
        ins_valid  = 4'b1111;
        outs_ready = 1'b0;
        #1;
        total++; if (ins_ready !== 4'b0001) begin bad++; $display("FAIL bp_first_ready got=%b exp=0001", ins_ready); end
        cycle();
        for (int c = 0; c < 5; c++) begin
            total++; if (ins_ready !== 4'b0000) begin bad++; $display("FAIL bp_stall_ready[%0d] got=%b exp=0000", c, ins_ready); end
            total++; if (outs_valid !== 1'b1 || outs_index !== 2'd0) begin bad++; $display("FAIL bp_stall_hold[%0d] got=%b/%0d exp=1/0", c, outs_valid, outs_index); end
            $display("backpressure stall %0d: ready=%b index=%0d", c, ins_ready, outs_index);
            cycle();
        end
        outs_ready = 1'b1;
        #1;
        total++; if (ins_ready !== e_next) begin bad++; $display("FAIL bp_refill_ready got=%b exp=%b", ins_ready, e_next); end
        cycle();
        total++; if (outs_valid !== 1'b1 || outs_index !== i_next) begin bad++; $display("FAIL bp_refill got=%b/%0d exp=1/%0d", outs_valid, outs_index, i_next); end
        $display("backpressure release: index=%0d", outs_index);
        ins_valid = 4'b0000;
        #1;
        total++; if (ins_ready !== 4'b0000) begin bad++; $display("FAIL drain_ready got=%b exp=0000", ins_ready); end
        cycle();
        total++; if (outs_valid !== 1'b0) begin bad++; $display("FAIL drain_valid got=%b exp=0", outs_valid); end
        total++; if (outs !== 32'h0001FB3C) begin bad++; $display("FAIL drain_outs got=%h exp=0001fb3c", outs); end
        $display("drain: valid=%b outs=%h", outs_valid, outs);
    endtask

    task automatic test_midreset();
        do_reset();
        ins_valid  = 4'b1111;
        outs_ready = 1'b1;
        cycle();
        outs_ready = 1'b0;
        cycle();
        total++; if (outs_valid !== 1'b1) begin bad++; $display("FAIL midrst_pre got=%b exp=1", outs_valid); end
        #2;
        rst = 1'b0;
        #1;
        total++; if (outs_valid !== 1'b0) begin bad++; $display("FAIL midrst_async got=%b exp=0", outs_valid); end
        total++; if (ins_ready !== 4'b0000) begin bad++; $display("FAIL midrst_ready got=%b exp=0000", ins_ready); end
        cycle();
        rst        = 1'b1;
        outs_ready = 1'b1;
        #1;
        total++; if (ins_ready !== 4'b0001) begin bad++; $display("FAIL midrst_release_ready got=%b exp=0001", ins_ready); end
        cycle();
        total++; if (outs_valid !== 1'b1 || outs_index !== 2'd0) begin bad++; $display("FAIL midrst_grant got=%b/%0d exp=1/0", outs_valid, outs_index); end
        $display("midreset: valid=%b index=%0d", outs_valid, outs_index);
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_sparse();
        test_backpressure();
        test_midreset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
